level_sequencer: RTL

- Game-level controller that sequences the loot-map generator: issues the start_level pulse and level_num, then waits out map generation.
- Snapshots the generator's total loot count, runs the per-level countdown timer and accumulates score from collected loot.
- Decides level pass, level fail or game won.
- Sits between the top-level game FSM/buttons and the loot matrix and HUD blocks.

---
 rtl/game_pkg.sv | 25 ++
 rtl/frame_second_timer.sv | 39 +++
 rtl/level_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: loot type codes, sequencer state encoding and
// the widths of the score/time/level/loot fields seen by the HUD.
package game_pkg;

  localparam logic [2:0] LOOT_NONE = 3'd0;
  localparam logic [2:0] LOOT_GOLD = 3'd1;
  localparam logic [2:0] LOOT_ROCK = 3'd2;

  localparam int SCORE_W = 16;
  localparam int TIME_W  = 7;
  localparam int LEVEL_W = 3;
  localparam int LOOT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GEN_WAIT,
    S_PLAY,
    S_EVAL,
    S_LEVEL_WON,
    S_GAME_OVER,
    S_GAME_WON
  } seq_state_t;

endpackage

// File: rtl/frame_second_timer.sv
// Level countdown: divides start_of_frame pulses down to seconds and counts
// time_left towards zero. load re-arms a full level; enable gates counting.
module frame_second_timer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int LEVEL_TIME_SEC = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic              start_of_frame,
  output logic [TIME_W-1:0] time_left
);

  localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [FC_W-1:0] frame_cnt;

  // Frame divider and seconds countdown; time_left holds at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      time_left <= '0;
    end else if (load) begin
      frame_cnt <= '0;
      time_left <= TIME_W'(LEVEL_TIME_SEC);
    end else if (enable && start_of_frame) begin
      if (frame_cnt == FC_W'(FRAMES_PER_SEC - 1)) begin
        frame_cnt <= '0;
        if (time_left != '0) time_left <= time_left - TIME_W'(1);
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-level controller: kicks the loot-map generator, waits out map
// generation, runs the level (timer, score, loot count) and decides
// pass / fail / game won. All outputs are registered.
module level_sequencer
  import game_pkg::*;
#(
  parameter int MAX_LEVEL       = 4,
  parameter int GEN_WAIT_CYCLES = 256,
  parameter int FRAMES_PER_SEC  = 60,
  parameter int LEVEL_TIME_SEC  = 60,
  parameter int GOLD_VALUE      = 50,
  parameter int ROCK_VALUE      = 10,
  parameter int TARGET_BASE     = 200,
  parameter int TARGET_STEP     = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_game,
  input  logic        continue_level,
  input  logic        start_of_frame,
  input  logic        loot_collected,
  input  logic [2:0]  collected_type,
  input  logic [7:0]  total_amount,
  output logic        start_level,
  output logic [2:0]  level_num,
  output logic [15:0] score,
  output logic [15:0] target,
  output logic [6:0]  time_left,
  output logic [7:0]  loot_left,
  output logic        playing,
  output logic        level_won,
  output logic        game_over,
  output logic        game_won
);

  localparam int WAIT_W = (GEN_WAIT_CYCLES > 1) ? $clog2(GEN_WAIT_CYCLES) : 1;

  seq_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              gen_done;
  logic              play_over;
  logic              play_active;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] loot_value(input logic [2:0] kind);
    case (kind)
      LOOT_GOLD: return SCORE_W'(GOLD_VALUE);
      LOOT_ROCK: return SCORE_W'(ROCK_VALUE);
      default:   return '0;
    endcase
  endfunction

  function automatic logic [SCORE_W-1:0] target_for(input logic [LEVEL_W-1:0] lvl);
    int t;
    t = TARGET_BASE + (int'(lvl) - 1) * TARGET_STEP;
    return SCORE_W'(t);
  endfunction

  assign gen_done    = (wait_cnt == WAIT_W'(GEN_WAIT_CYCLES - 1));
  assign play_over   = (time_left == '0) || (loot_left == '0);
  // The level is live only until a terminal count is seen; the following
  // clock is spent leaving PLAY with nothing further applied.
  assign play_active = (state == S_PLAY) && !play_over;

  frame_second_timer #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC),
    .LEVEL_TIME_SEC (LEVEL_TIME_SEC)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .load           (state == S_LOAD),
    .enable         (play_active),
    .start_of_frame (start_of_frame),
    .time_left      (time_left)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; pulses not listed for a state are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_GAME_OVER, S_GAME_WON: if (start_game) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_GEN_WAIT;
      S_GEN_WAIT:  if (gen_done) state_nxt = S_PLAY;
      S_PLAY:      if (play_over) state_nxt = S_EVAL;
      S_EVAL: begin
        if (score >= target)
          state_nxt = (level_num == LEVEL_W'(MAX_LEVEL)) ? S_GAME_WON : S_LEVEL_WON;
        else
          state_nxt = S_GAME_OVER;
      end
      S_LEVEL_WON: if (continue_level) state_nxt = S_LOAD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Level data: level number, target, score, loot count and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_num <= '0;
      score     <= '0;
      target    <= '0;
      loot_left <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_GAME_OVER, S_GAME_WON: begin
          if (start_game) begin
            score     <= '0;
            level_num <= LEVEL_W'(1);
          end
        end
        S_LOAD: begin
          target   <= target_for(level_num);
          wait_cnt <= '0;
        end
        S_GEN_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (gen_done) loot_left <= total_amount;
        end
        S_PLAY: begin
          if (play_active && loot_collected) begin
            score     <= sat_add(score, loot_value(collected_type));
            loot_left <= loot_left - LOOT_W'(1);
          end
        end
        S_LEVEL_WON: begin
          if (continue_level) level_num <= level_num + LEVEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status flags, one clock behind the state they report.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_level <= 1'b0;
      playing     <= 1'b0;
      level_won   <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      start_level <= (state == S_LOAD);
      playing     <= (state == S_PLAY);
      level_won   <= (state == S_LEVEL_WON);
      game_over   <= (state == S_GAME_OVER);
      game_won    <= (state == S_GAME_WON);
    end
  end

endmodule
